// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit: one outstanding RISC-V load/store against a synchronous dmem.
// Define MISALIGN_TRAP_EN to turn misaligned H/W accesses into error responses.
module lsu_dmem_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [1:0]    mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_reg, state_next;
  logic          we_reg, we_next;
  logic [2:0]    funct3_reg, funct3_next;
  logic [1:0]    offset_reg, offset_next;
  logic          err_reg, err_next;
  logic [DW-1:0] load_data_reg, load_data_next;

  logic          req_ready_next, rsp_valid_next, rsp_err_next;
  logic [DW-1:0] rsp_rdata_next;
  logic [1:0]    mem_en_next;
  logic [3:0]    mem_we_next;
  logic [AW-1:0] mem_addr_next;
  logic [DW-1:0] mem_din_next;

  logic          accept, funct3_ok, misaligned, req_err;
  logic [1:0]    req_offset;
  logic [3:0]    size_lanes;
  logic [DW-1:0] size_mask, shifted_dout, extended_dout;

  assign accept = req_valid && req_ready;

  always_comb begin
    funct3_ok = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
      3'b100, 3'b101:         funct3_ok = !req_we;
      default:                funct3_ok = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_offset = req_addr[1:0];
`else
  assign misaligned = 1'b0;
  // Misaligned halfwords/words are silently rounded down to their natural alignment.
  always_comb begin
    req_offset = 2'b00;
    case (req_funct3[1:0])
      2'b00:   req_offset = req_addr[1:0];
      2'b01:   req_offset = {req_addr[1], 1'b0};
      default: req_offset = 2'b00;
    endcase
  end
`endif

  assign req_err = !funct3_ok || misaligned;

  always_comb begin
    size_lanes = 4'b1111;
    size_mask  = '1;
    case (req_funct3[1:0])
      2'b00:   begin size_lanes = 4'b0001; size_mask = 32'h0000_00FF; end
      2'b01:   begin size_lanes = 4'b0011; size_mask = 32'h0000_FFFF; end
      default: begin size_lanes = 4'b1111; size_mask = '1;            end
    endcase
  end

  assign shifted_dout = mem_dout >> {offset_reg, 3'b000};

  always_comb begin
    extended_dout = shifted_dout;
    case (funct3_reg)
      3'b000:  extended_dout = {{24{shifted_dout[7]}}, shifted_dout[7:0]};
      3'b001:  extended_dout = {{16{shifted_dout[15]}}, shifted_dout[15:0]};
      3'b100:  extended_dout = {24'h0, shifted_dout[7:0]};
      3'b101:  extended_dout = {16'h0, shifted_dout[15:0]};
      default: extended_dout = shifted_dout;
    endcase
  end

  // Every output is a register loaded with the value it must show in the next state.
  always_comb begin
    state_next     = state_reg;
    we_next        = we_reg;
    funct3_next    = funct3_reg;
    offset_next    = offset_reg;
    err_next       = err_reg;
    load_data_next = load_data_reg;
    mem_en_next    = 2'b00;
    mem_we_next    = 4'b0000;
    mem_addr_next  = mem_addr;
    mem_din_next   = mem_din;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = '0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          we_next     = req_we;
          funct3_next = req_funct3;
          offset_next = req_offset;
          err_next    = req_err;
          if (req_err) begin
            state_next = RESP;
          end else begin
            state_next    = ISSUE;
            mem_en_next   = req_we ? 2'b10 : 2'b01;
            mem_we_next   = req_we ? (size_lanes << req_offset) : 4'b0000;
            mem_addr_next = {req_addr[AW-1:2], 2'b00};
            if (req_we) begin
              mem_din_next = (req_wdata & size_mask) << {req_offset, 3'b000};
            end
          end
        end
      end
      ISSUE: state_next = we_reg ? RESP : WAIT;
      WAIT: begin
        load_data_next = extended_dout;
        state_next     = RESP;
      end
      RESP: begin
        state_next     = IDLE;
        rsp_valid_next = 1'b1;
        rsp_err_next   = err_reg;
        rsp_rdata_next = (err_reg || we_reg) ? '0 : load_data_reg;
      end
      default: state_next = IDLE;
    endcase
    req_ready_next = (state_next == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg        <= 1'b0;
      funct3_reg    <= 3'b000;
      offset_reg    <= 2'b00;
      err_reg       <= 1'b0;
      load_data_reg <= '0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
      mem_en        <= 2'b00;
      mem_we        <= 4'b0000;
      mem_addr      <= '0;
      mem_din       <= '0;
    end else begin
      we_reg        <= we_next;
      funct3_reg    <= funct3_next;
      offset_reg    <= offset_next;
      err_reg       <= err_next;
      load_data_reg <= load_data_next;
      req_ready     <= req_ready_next;
      rsp_valid     <= rsp_valid_next;
      rsp_err       <= rsp_err_next;
      rsp_rdata     <= rsp_rdata_next;
      mem_en        <= mem_en_next;
      mem_we        <= mem_we_next;
      mem_addr      <= mem_addr_next;
      mem_din       <= mem_din_next;
    end
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench for lsu_dmem_ctrl: directed vectors plus random traffic
// checked against a byte-addressed reference memory.
`timescale 1ns/1ps
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_din, mem_dout;

  always #5 clk = ~clk;

  lsu_dmem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Synchronous dmem, 16 words, registered read.
  logic [31:0] dmem [0:15];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) dmem[i] <= '0;
      mem_dout <= '0;
    end else begin
      if (mem_en == 2'b10)
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) dmem[mem_addr[5:2]][8*b +: 8] <= mem_din[8*b +: 8];
      if (mem_en == 2'b01) mem_dout <= dmem[mem_addr[5:2]];
    end
  end

  logic [7:0] ref_mem [0:63];
  int n_checks = 0;
  int n_pass   = 0;

  logic        obs_ready_at_drive, obs_busy_ready, obs_ready_after, obs_err;
  int          obs_lat, obs_en_cycles, obs_en_k;
  logic [1:0]  obs_en;
  logic [3:0]  obs_we;
  logic [31:0] obs_addr, obs_din, obs_rdata;

  logic        e_err;
  int          e_lat;
  logic [1:0]  e_en;
  logic [3:0]  e_we;
  logic [31:0] e_addr, e_din, e_rdata;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
  endtask

  // Drive one request, then observe outputs each cycle until the response (bounded).
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    obs_ready_at_drive = req_ready;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    obs_lat = -1; obs_en_cycles = 0; obs_en_k = -1; obs_en = 2'b00; obs_we = 4'b0;
    obs_addr = '0; obs_din = '0; obs_busy_ready = 1'b0; obs_ready_after = 1'b0;
    obs_err = 1'b0; obs_rdata = '0;
    for (int k = 0; k < 8 && obs_lat < 0; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (mem_en != 2'b00) begin
        obs_en_cycles++;
        if (obs_en_k < 0) begin
          obs_en_k = k; obs_en = mem_en; obs_we = mem_we; obs_addr = mem_addr; obs_din = mem_din;
        end
      end
      if (rsp_valid) begin
        obs_lat = k; obs_err = rsp_err; obs_rdata = rsp_rdata; obs_ready_after = req_ready;
      end else if (req_ready) begin
        obs_busy_ready = 1'b1;
      end
    end
    $display("txn we=%0d f3=%03b addr=%08h wdata=%08h en=%02b we=%04b din=%08h lat=%0d err=%0d rdata=%08h",
             we, f3, addr, wdata, obs_en, obs_we, obs_din, obs_lat, obs_err, obs_rdata);
  endtask

  // Reference: byte-addressed memory, access size from funct3, aligned-down address when not trapping.
  task automatic model_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int size, lane;
    logic legal, mis;
    logic [31:0] ea, val;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
`ifdef MISALIGN_TRAP_EN
    mis = (addr % 32'(size)) != 0;
    ea  = addr;
`else
    mis = 1'b0;
    ea  = addr - (addr % 32'(size));
`endif
    e_err = !legal || mis;
    e_en = 2'b00; e_we = 4'b0; e_din = '0; e_rdata = '0;
    e_addr = ea & 32'hFFFF_FFFC;
    if (e_err) begin
      e_lat = 1;
    end else if (we) begin
      e_lat = 2; e_en = 2'b10;
      for (int i = 0; i < size; i++) begin
        lane = int'(ea[1:0]) + i;
        e_we[lane] = 1'b1;
        e_din[8*lane +: 8] = wdata[8*i +: 8];
        ref_mem[int'(ea[5:0]) + i] = wdata[8*i +: 8];
      end
    end else begin
      e_lat = 3; e_en = 2'b01; val = '0;
      for (int i = 0; i < size; i++) val[8*i +: 8] = ref_mem[int'(ea[5:0]) + i];
      if (!f3[2] && size < 4 && val[8*size-1])
        for (int j = 8*size; j < 32; j++) val[j] = 1'b1;
      e_rdata = val;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %0b want 0", rsp_err); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata: got %08h want 0", rsp_rdata); else n_pass++;
    n_checks++; if (mem_en !== 2'b00) $display("FAIL reset_mem_en: got %02b want 00", mem_en); else n_pass++;
    n_checks++; if (mem_we !== 4'b0) $display("FAIL reset_mem_we: got %04b want 0000", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %08h want 0", mem_addr); else n_pass++;
    n_checks++; if (mem_din !== 32'h0) $display("FAIL reset_mem_din: got %08h want 0", mem_din); else n_pass++;
  endtask

  task automatic test_store();
    do_txn(1'b1, 3'b010, 32'h0010_0000, 32'h2022_1118);
    n_checks++; if (obs_en !== 2'b10) $display("FAIL sw_en: got %02b want 10", obs_en); else n_pass++;
    n_checks++; if (obs_we !== 4'b1111) $display("FAIL sw_we: got %04b want 1111", obs_we); else n_pass++;
    n_checks++; if (obs_addr !== 32'h0010_0000) $display("FAIL sw_addr: got %08h want 00100000", obs_addr); else n_pass++;
    n_checks++; if (obs_din !== 32'h2022_1118) $display("FAIL sw_din: got %08h want 20221118", obs_din); else n_pass++;
    n_checks++; if (obs_lat !== 2) $display("FAIL sw_latency: got %0d want 2", obs_lat); else n_pass++;
    n_checks++; if (obs_err !== 1'b0) $display("FAIL sw_err: got %0b want 0", obs_err); else n_pass++;
    do_txn(1'b1, 3'b000, 32'h0010_0003, 32'h0000_00A5);
    n_checks++; if (obs_we !== 4'b1000) $display("FAIL sb_we: got %04b want 1000", obs_we); else n_pass++;
    n_checks++; if (obs_din !== 32'hA500_0000) $display("FAIL sb_din: got %08h want A5000000", obs_din); else n_pass++;
    n_checks++; if (obs_addr !== 32'h0010_0000) $display("FAIL sb_addr: got %08h want 00100000", obs_addr); else n_pass++;
  endtask

  task automatic test_load();
    do_txn(1'b1, 3'b010, 32'h0010_0000, 32'h1198_7251);
    do_txn(1'b0, 3'b000, 32'h0010_0002, 32'h0);
    n_checks++; if (obs_rdata !== 32'hFFFF_FF98) $display("FAIL lb_rdata: got %08h want FFFFFF98", obs_rdata); else n_pass++;
    n_checks++; if (obs_lat !== 3) $display("FAIL lb_latency: got %0d want 3", obs_lat); else n_pass++;
    do_txn(1'b0, 3'b100, 32'h0010_0002, 32'h0);
    n_checks++; if (obs_rdata !== 32'h0000_0098) $display("FAIL lbu_rdata: got %08h want 00000098", obs_rdata); else n_pass++;
    do_txn(1'b1, 3'b010, 32'h0010_0004, 32'h1879_0475);
    do_txn(1'b0, 3'b001, 32'h0010_0006, 32'h0);
    n_checks++; if (obs_en !== 2'b01) $display("FAIL lh_en: got %02b want 01", obs_en); else n_pass++;
    n_checks++; if (obs_addr !== 32'h0010_0004) $display("FAIL lh_addr: got %08h want 00100004", obs_addr); else n_pass++;
    n_checks++; if (obs_rdata !== 32'h0000_1879) $display("FAIL lh_rdata: got %08h want 00001879", obs_rdata); else n_pass++;
  endtask

  task automatic test_misalign();
    do_txn(1'b0, 3'b010, 32'h0010_0002, 32'h0);
`ifdef MISALIGN_TRAP_EN
    n_checks++; if (obs_err !== 1'b1) $display("FAIL lw_mis_err: got %0b want 1", obs_err); else n_pass++;
    n_checks++; if (obs_lat !== 1) $display("FAIL lw_mis_latency: got %0d want 1", obs_lat); else n_pass++;
    n_checks++; if (obs_en_cycles !== 0) $display("FAIL lw_mis_mem_en: got %0d active cycles want 0", obs_en_cycles); else n_pass++;
`else
    n_checks++; if (obs_err !== 1'b0) $display("FAIL lw_mis_err: got %0b want 0", obs_err); else n_pass++;
    n_checks++; if (obs_addr !== 32'h0010_0000) $display("FAIL lw_mis_addr: got %08h want 00100000", obs_addr); else n_pass++;
    n_checks++; if (obs_rdata !== 32'h1198_7251) $display("FAIL lw_mis_rdata: got %08h want 11987251", obs_rdata); else n_pass++;
`endif
  endtask

  task automatic test_bad_funct3();
    logic [3:0] cases [6] = '{4'b0011, 4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b1011};
    for (int i = 0; i < 6; i++) begin
      logic [3:0] c;
      c = cases[i];
      do_txn(c[3], c[2:0], 32'h0010_0008, 32'hDEAD_BEEF);
      n_checks++; if (obs_err !== 1'b1) $display("FAIL bad_f3_err[%0d]: got %0b want 1", i, obs_err); else n_pass++;
      n_checks++; if (obs_rdata !== 32'h0) $display("FAIL bad_f3_rdata[%0d]: got %08h want 0", i, obs_rdata); else n_pass++;
      n_checks++; if (obs_lat !== 1) $display("FAIL bad_f3_latency[%0d]: got %0d want 1", i, obs_lat); else n_pass++;
      n_checks++; if (obs_en_cycles !== 0) $display("FAIL bad_f3_mem_en[%0d]: got %0d active cycles want 0", i, obs_en_cycles); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic seen, issue_en;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0010_0000; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    issue_en = (mem_en == 2'b01);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    n_checks++; if (issue_en !== 1'b1) $display("FAIL rst_mid_issue: got %0b want 1", issue_en); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_mid_rsp_valid: got %0b want 0", rsp_valid); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_mid_ready: got %0b want 1", req_ready); else n_pass++;
    n_checks++; if (mem_en !== 2'b00) $display("FAIL rst_mid_mem_en: got %02b want 00", mem_en); else n_pass++;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) $display("FAIL rst_mid_late_rsp: got %0b want 0", seen); else n_pass++;
  endtask

  task automatic test_random();
    logic we;
    logic [2:0] f3;
    logic [31:0] addr, wdata;
    for (int t = 0; t < 200; t++) begin
      we = 1'($urandom); f3 = 3'($urandom_range(0, 7));
      addr = 32'h0010_0000 | 32'($urandom_range(0, 63)); wdata = $urandom;
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
      model_txn(we, f3, addr, wdata);
      do_txn(we, f3, addr, wdata);
      n_checks++; if (obs_lat !== e_lat) $display("FAIL rnd_latency[%0d]: got %0d want %0d", t, obs_lat, e_lat); else n_pass++;
      n_checks++; if (obs_err !== e_err) $display("FAIL rnd_err[%0d]: got %0b want %0b", t, obs_err, e_err); else n_pass++;
      n_checks++; if (obs_rdata !== e_rdata) $display("FAIL rnd_rdata[%0d]: got %08h want %08h", t, obs_rdata, e_rdata); else n_pass++;
      n_checks++; if (obs_en_cycles !== (e_err ? 0 : 1)) $display("FAIL rnd_en_cycles[%0d]: got %0d want %0d", t, obs_en_cycles, e_err ? 0 : 1); else n_pass++;
      n_checks++; if (obs_busy_ready !== 1'b0) $display("FAIL rnd_busy_ready[%0d]: got %0b want 0", t, obs_busy_ready); else n_pass++;
      n_checks++; if (obs_ready_after !== 1'b1) $display("FAIL rnd_ready_after[%0d]: got %0b want 1", t, obs_ready_after); else n_pass++;
      if (!e_err) begin
        n_checks++; if (obs_en_k !== 0) $display("FAIL rnd_issue_cycle[%0d]: got %0d want 0", t, obs_en_k); else n_pass++;
        n_checks++; if (obs_en !== e_en) $display("FAIL rnd_en[%0d]: got %02b want %02b", t, obs_en, e_en); else n_pass++;
        n_checks++; if (obs_addr !== e_addr) $display("FAIL rnd_addr[%0d]: got %08h want %08h", t, obs_addr, e_addr); else n_pass++;
        n_checks++; if (obs_we !== e_we) $display("FAIL rnd_we[%0d]: got %04b want %04b", t, obs_we, e_we); else n_pass++;
        if (we) begin
          n_checks++; if (obs_din !== e_din) $display("FAIL rnd_din[%0d]: got %08h want %08h", t, obs_din, e_din); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    model_txn(1'b1, 3'b010, 32'h0010_0010, 32'hCAFE_F00D);
    do_txn(1'b1, 3'b010, 32'h0010_0010, 32'hCAFE_F00D);
    model_txn(1'b0, 3'b001, 32'h0010_0012, 32'h0);
    do_txn(1'b0, 3'b001, 32'h0010_0012, 32'h0);
    n_checks++; if (obs_ready_at_drive !== 1'b1) $display("FAIL b2b_ready: got %0b want 1", obs_ready_at_drive); else n_pass++;
    n_checks++; if (obs_rdata !== e_rdata) $display("FAIL b2b_rdata: got %08h want %08h", obs_rdata, e_rdata); else n_pass++;
    n_checks++; if (obs_lat !== 3) $display("FAIL b2b_latency: got %0d want 3", obs_lat); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
    test_reset();
    test_store();
    test_load();
    test_misalign();
    test_bad_funct3();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
